// File: rtl/hmmm_program_loader_pkg.sv
// rtl/hmmm_program_loader_pkg.sv - shared widths and state encodings for the hmmm program loader
package hmmm_program_loader_pkg;

    localparam int HMMM_ADDR_W = 8;
    localparam int HMMM_DATA_W = 16;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_LEN  = 4'd1,
        S_HI   = 4'd2,
        S_LO   = 4'd3,
        S_ADDR = 4'd4,
        S_DATA = 4'd5,
        S_CSUM = 4'd6,
        S_DONE = 4'd7,
        S_ERR  = 4'd8
    } state_t;

endpackage

// File: rtl/hmmm_word_packer.sv
// rtl/hmmm_word_packer.sv - HI/LO byte capture into a bus word plus running XOR checksum
module hmmm_word_packer
    import hmmm_program_loader_pkg::*;
#(
    parameter int DATA_W = HMMM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_strobe,
    input  logic              hi_strobe,
    input  logic              lo_strobe,
    input  logic [7:0]        in_byte,
    output logic [DATA_W-1:0] word,
    output logic [7:0]        csum
);

    logic [7:0] r_hi;
    logic [7:0] r_lo;
    logic [7:0] r_csum;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hi   <= 8'd0;
            r_lo   <= 8'd0;
            r_csum <= 8'd0;
        end else if (clear) begin
            r_hi   <= 8'd0;
            r_lo   <= 8'd0;
            r_csum <= 8'd0;
        end else begin
            if (hi_strobe)   r_hi   <= in_byte;
            if (lo_strobe)   r_lo   <= in_byte;
            if (byte_strobe) r_csum <= r_csum ^ in_byte;
        end
    end

    assign word = DATA_W'({r_hi, r_lo});
    assign csum = r_csum;

endmodule

// File: rtl/hmmm_program_loader.sv
// rtl/hmmm_program_loader.sv - streams a length/word/checksum frame into core RAM over the shared bus
module hmmm_program_loader
    import hmmm_program_loader_pkg::*;
#(
    parameter int ADDR_W = HMMM_ADDR_W,
    parameter int DATA_W = HMMM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              pgrm_addr,
    output logic              pgrm_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_words;
    logic [ADDR_W:0]   r_len;
    logic              w_xfer;
    logic              w_clear;
    logic              w_last;
    logic [DATA_W-1:0] w_word;
    logic [7:0]        w_csum;

    assign w_xfer  = in_valid & in_ready;
    assign w_clear = start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR));
    assign w_last  = (r_words + 1'b1) == r_len;

    hmmm_word_packer #(.DATA_W(DATA_W)) u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear       (w_clear),
        .byte_strobe (w_xfer & ((r_state == S_LEN) | (r_state == S_HI) | (r_state == S_LO))),
        .hi_strobe   (w_xfer & (r_state == S_HI)),
        .lo_strobe   (w_xfer & (r_state == S_LO)),
        .in_byte     (in_data),
        .word        (w_word),
        .csum        (w_csum)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_words <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_next;
            if (w_clear) begin
                r_addr  <= '0;
                r_words <= '0;
            end
            // A zero length byte stands for a full 256-word image.
            if (w_xfer && r_state == S_LEN) begin
                r_len <= (in_data == 8'd0) ? (ADDR_W+1)'(256) : (ADDR_W+1)'(in_data);
            end
            if (r_state == S_DATA) begin
                r_addr  <= r_addr + 1'b1;
                r_words <= r_words + 1'b1;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        bus_oe    = 1'b0;
        bus_out   = '0;
        pgrm_addr = 1'b0;
        pgrm_data = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next = S_LEN;
            S_LEN: begin
                in_ready = 1'b1;
                if (w_xfer) w_next = S_HI;
            end
            S_HI: begin
                in_ready = 1'b1;
                if (w_xfer) w_next = S_LO;
            end
            S_LO: begin
                in_ready = 1'b1;
                if (w_xfer) w_next = S_ADDR;
            end
            S_ADDR: begin
                bus_oe    = 1'b1;
                bus_out   = DATA_W'(r_addr);
                pgrm_addr = 1'b1;
                w_next    = S_DATA;
            end
            S_DATA: begin
                bus_oe    = 1'b1;
                bus_out   = w_word;
                pgrm_data = 1'b1;
                w_next    = w_last ? S_CSUM : S_HI;
            end
            S_CSUM: begin
                in_ready = 1'b1;
                if (w_xfer) w_next = (in_data == w_csum) ? S_DONE : S_ERR;
            end
            S_DONE, S_ERR: if (start) w_next = S_LEN;
            default: w_next = S_IDLE;
        endcase
    end

    assign cpu_hold     = (r_state != S_DONE);
    assign done         = (r_state == S_DONE);
    assign error        = (r_state == S_ERR);
    assign words_loaded = r_words;

endmodule

// File: tb/tb_hmmm_program_loader.sv
// tb/tb_hmmm_program_loader.sv - directed self-checking bench for hmmm_program_loader
module tb_hmmm_program_loader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic              pgrm_addr;
    logic              pgrm_data;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    hmmm_program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .bus_out      (bus_out),
        .bus_oe       (bus_oe),
        .pgrm_addr    (pgrm_addr),
        .pgrm_data    (pgrm_data),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Core-side model: MAR latch, RAM image, strobe log and protocol violation count
    logic [7:0]  mar = 8'd0;
    logic [15:0] ram [256];
    logic [16:0] slog[$];
    int          viol = 0;

    always @(posedge clk) begin
        if (rst) begin
            if (pgrm_addr) begin
                mar <= bus_out[7:0];
                slog.push_back({1'b0, bus_out});
            end
            if (pgrm_data) begin
                ram[mar] <= bus_out;
                slog.push_back({1'b1, bus_out});
            end
            if (pgrm_addr && pgrm_data) viol++;
            if (bus_oe && in_ready) viol++;
            if ((pgrm_addr || pgrm_data) && !bus_oe) viol++;
        end
    end

    task automatic clear_ram();
        for (int i = 0; i < 256; i++) ram[i] = 16'hDEAD;
        slog.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("send_timeout", 32'(n), 32'd0);
        @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] f[$], input bit gaps, input int start_at);
        for (int i = 0; i < f.size(); i++) begin
            if (i == start_at) begin
                @(negedge clk);
                in_valid = 1'b0;
                pulse_start();
            end
            send_byte(f[i], gaps ? int'($urandom_range(0, 3)) : 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while (!(done || error) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 5000), 32'd1);
    endtask

    task automatic check_two_word_log(input string tag);
        check({tag, "_nlog"}, 32'(slog.size()), 32'd4);
        if (slog.size() == 4) begin
            check({tag, "_a0"}, 32'(slog[0]), {15'd0, 17'h00000});
            check({tag, "_d0"}, 32'(slog[1]), {15'd0, 17'h11234});
            check({tag, "_a1"}, 32'(slog[2]), {15'd0, 17'h00001});
            check({tag, "_d1"}, 32'(slog[3]), {15'd0, 17'h1ABCD});
        end
    endtask

    logic [7:0] frame_good[$];
    logic [7:0] frame_bad[$];
    logic [7:0] frame_big[$];
    logic [7:0] cs;
    int         n_addr;
    logic [15:0] last_addr;
    int          n;

    initial begin
        frame_good = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        frame_bad  = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00};

        // 1: reset values
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_bus_oe", 32'(bus_oe), 32'd0);
        check("rst_bus_out", 32'(bus_out), 32'd0);
        check("rst_pgrm_addr", 32'(pgrm_addr), 32'd0);
        check("rst_pgrm_data", 32'(pgrm_data), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd0);

        // 2: good two-word frame, stream held valid
        clear_ram();
        pulse_start();
        check("len_in_ready", 32'(in_ready), 32'd1);
        send_frame(frame_good, 1'b0, -1);
        wait_end("t2_end");
        check_two_word_log("t2");
        check("t2_done", 32'(done), 32'd1);
        check("t2_error", 32'(error), 32'd0);
        check("t2_cpu_hold", 32'(cpu_hold), 32'd0);
        check("t2_words", 32'(words_loaded), 32'd2);
        check("t2_in_ready", 32'(in_ready), 32'd0);

        // 3: checksum mismatch
        clear_ram();
        pulse_start();
        check("t3_cleared_done", 32'(done), 32'd0);
        check("t3_cleared_words", 32'(words_loaded), 32'd0);
        send_frame(frame_bad, 1'b0, -1);
        wait_end("t3_end");
        check("t3_error", 32'(error), 32'd1);
        check("t3_done", 32'(done), 32'd0);
        check("t3_cpu_hold", 32'(cpu_hold), 32'd1);
        check("t3_ram0", 32'(ram[0]), 32'h1234);
        check("t3_ram1", 32'(ram[1]), 32'hABCD);

        // 4: valid gaps and a start pulse in the middle of the frame
        clear_ram();
        pulse_start();
        send_frame(frame_good, 1'b1, 3);
        wait_end("t4_end");
        check_two_word_log("t4");
        check("t4_done", 32'(done), 32'd1);
        check("t4_words", 32'(words_loaded), 32'd2);

        // 5: LEN=0 loads 256 words
        frame_big.delete();
        frame_big.push_back(8'h00);
        cs = 8'h00;
        for (int i = 0; i < 256; i++) begin
            frame_big.push_back(8'(i));
            frame_big.push_back(8'(i) ^ 8'h5A);
            cs = cs ^ 8'(i) ^ (8'(i) ^ 8'h5A);
        end
        frame_big.push_back(cs);
        clear_ram();
        pulse_start();
        send_frame(frame_big, 1'b0, -1);
        wait_end("t5_end");
        check("t5_done", 32'(done), 32'd1);
        check("t5_words", 32'(words_loaded), 32'd256);
        n_addr = 0;
        last_addr = 16'hFFFF;
        foreach (slog[i]) begin
            if (!slog[i][16]) begin
                n_addr++;
                last_addr = slog[i][15:0];
            end
        end
        check("t5_n_addr", 32'(n_addr), 32'd256);
        check("t5_last_addr", 32'(last_addr), 32'h00FF);
        check("t5_ram0", 32'(ram[0]), 32'h005A);
        check("t5_ram80", 32'(ram[8'h80]), 32'h80DA);
        check("t5_ramff", 32'(ram[8'hFF]), 32'hFFA5);

        // 6: reset during DATA of word 1, then a clean reload
        clear_ram();
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(frame_good[i], 0);
        n = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (!(pgrm_data && bus_out == 16'hABCD) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_reach_data", 32'(n < 20), 32'd1);
        check("t6_words_mid", 32'(words_loaded), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("t6_bus_oe", 32'(bus_oe), 32'd0);
        check("t6_pgrm_data", 32'(pgrm_data), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd0);
        check("t6_words", 32'(words_loaded), 32'd0);
        check("t6_cpu_hold", 32'(cpu_hold), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_idle_in_ready", 32'(in_ready), 32'd0);
        clear_ram();
        pulse_start();
        send_frame(frame_good, 1'b0, -1);
        wait_end("t6_end");
        check_two_word_log("t6");
        check("t6_done", 32'(done), 32'd1);
        check("t6_ram0", 32'(ram[0]), 32'h1234);

        check("protocol_violations", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
